aes_mem_block_master: RTL and testbench

//  Avalon-MM initiator for the AES on-chip RAM (32-bit, single-port, 1-cycle read latency, no waitrequest).
//  Per job: reads num_blocks 128-bit plaintext blocks from src_addr, streams each to the AES core (pt_*).

---
 rtl/aes_mem_pkg.sv | 45 ++++
 rtl/aes_mem_block_master.sv | 217 +++++++++++++++++++++
 tb/tb_aes_mem_block_master.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_mem_pkg.sv
// rtl/aes_mem_pkg.sv - shared types and constants for the AES RAM block master
package aes_mem_pkg;

  // 128-bit AES block carried as four 32-bit RAM words
  localparam int WORDS_PER_BLK = 4;
  // on-chip RAM returns read data one cycle after the address
  localparam int RD_LAT        = 1;
  localparam int BLK_W         = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_PT,
    ST_CT,
    ST_WR,
    ST_DONE
  } state_e;

  // Word k of a block; word 0 is the most significant (big-endian across words)
  function automatic logic [31:0] blk_word(input logic [BLK_W-1:0] blk, input logic [1:0] k);
    logic [31:0] w;
    case (k)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

  // Replace word k of a block, same word ordering as blk_word
  function automatic logic [BLK_W-1:0] blk_put(input logic [BLK_W-1:0] blk, input logic [1:0] k,
                                               input logic [31:0] w);
    logic [BLK_W-1:0] r;
    r = blk;
    case (k)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      default: r[31:0]   = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_mem_block_master.sv
// rtl/aes_mem_block_master.sv - RAM-to-AES-to-RAM block mover, one block in flight
module aes_mem_block_master
  import aes_mem_pkg::*;
#(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 32,
  parameter int BLK_CNT_W = 12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    src_addr,
  input  logic [ADDR_W-1:0]    dst_addr,
  input  logic [BLK_CNT_W-1:0] num_blocks,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W-1:0]    avm_address,
  output logic                 avm_chipselect,
  output logic                 avm_write,
  output logic [3:0]           avm_byteenable,
  output logic [DATA_W-1:0]    avm_writedata,
  output logic                 avm_clken,
  input  logic [DATA_W-1:0]    avm_readdata,
  output logic                 pt_valid,
  input  logic                 pt_ready,
  output logic [BLK_W-1:0]     pt_data,
  input  logic                 ct_valid,
  output logic                 ct_ready,
  input  logic [BLK_W-1:0]     ct_data
);

  // RD runs one cycle longer than the word count to absorb the read latency
  localparam logic [2:0]        RD_LAST    = 3'(WORDS_PER_BLK + RD_LAT - 1);
  localparam logic [2:0]        LAST_WORD  = 3'(WORDS_PER_BLK - 1);
  localparam logic [ADDR_W-1:0] BLK_STRIDE = ADDR_W'(WORDS_PER_BLK);

  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [ADDR_W-1:0]    src_q, src_d;
  logic [ADDR_W-1:0]    dst_q, dst_d;
  logic [BLK_CNT_W-1:0] rem_q, rem_d;
  logic [BLK_W-1:0]     pt_q, pt_d;
  logic [BLK_W-1:0]     ct_q, ct_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 cs_q, cs_d;
  logic                 wr_q, wr_d;
  logic [3:0]           be_q, be_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 ptv_q, ptv_d;
  logic                 ctr_q, ctr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Next-state and next-output logic; bus outputs are decided one cycle ahead so they leave flops
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    pt_d    = pt_q;
    ct_d    = ct_q;
    addr_d  = addr_q;
    cs_d    = 1'b0;
    wr_d    = 1'b0;
    wdata_d = '0;
    ptv_d   = 1'b0;
    ctr_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d = src_addr;
          dst_d = dst_addr;
          rem_d = num_blocks;
          cnt_d = '0;
          if (num_blocks != '0) begin
            state_d = ST_RD;
            addr_d  = src_addr;
            cs_d    = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_RD: begin
        // cycle c>0 returns the word addressed in cycle c-1
        if (cnt_q != 3'd0) begin
          pt_d = blk_put(pt_q, cnt_q[1:0] - 2'd1, avm_readdata);
        end
        if (cnt_q < LAST_WORD) begin
          cs_d   = 1'b1;
          addr_d = src_q + ADDR_W'(cnt_q) + ADDR_W'(1);
        end
        if (cnt_q == RD_LAST) begin
          state_d = ST_PT;
          cnt_d   = '0;
          src_d   = src_q + BLK_STRIDE;
          ptv_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      ST_PT: begin
        ptv_d = 1'b1;
        if (pt_ready) begin
          state_d = ST_CT;
          ptv_d   = 1'b0;
          ctr_d   = 1'b1;
        end
      end

      ST_CT: begin
        ctr_d = 1'b1;
        if (ct_valid) begin
          ct_d    = ct_data;
          state_d = ST_WR;
          ctr_d   = 1'b0;
          cnt_d   = '0;
          cs_d    = 1'b1;
          wr_d    = 1'b1;
          addr_d  = dst_q;
          // ct_q is only loaded at this edge, so word 0 comes straight from the input
          wdata_d = blk_word(ct_data, 2'd0);
        end
      end

      ST_WR: begin
        if (cnt_q < LAST_WORD) begin
          cs_d    = 1'b1;
          wr_d    = 1'b1;
          addr_d  = dst_q + ADDR_W'(cnt_q) + ADDR_W'(1);
          wdata_d = blk_word(ct_q, cnt_q[1:0] + 2'd1);
          cnt_d   = cnt_q + 3'd1;
        end else begin
          dst_d = dst_q + BLK_STRIDE;
          rem_d = rem_q - BLK_CNT_W'(1);
          cnt_d = '0;
          if (rem_q != BLK_CNT_W'(1)) begin
            state_d = ST_RD;
            cs_d    = 1'b1;
            addr_d  = src_q;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    be_d   = cs_d ? 4'hF : 4'h0;
    busy_d = (state_d == ST_RD) || (state_d == ST_PT) || (state_d == ST_CT) || (state_d == ST_WR);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers; reset abandons any job and silences the bus immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      pt_q    <= '0;
      ct_q    <= '0;
      addr_q  <= '0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= 4'h0;
      wdata_q <= '0;
      ptv_q   <= 1'b0;
      ctr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      pt_q    <= pt_d;
      ct_q    <= ct_d;
      addr_q  <= addr_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      ptv_q   <= ptv_d;
      ctr_q   <= ctr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign avm_address    = addr_q;
  assign avm_chipselect = cs_q;
  assign avm_write      = wr_q;
  assign avm_byteenable = be_q;
  assign avm_writedata  = wdata_q;
  // the RAM is never clock-gated by this master
  assign avm_clken      = 1'b1;
  assign pt_valid       = ptv_q;
  assign pt_data        = pt_q;
  assign ct_ready       = ctr_q;

endmodule

// File: tb/tb_aes_mem_block_master.sv
// tb/tb_aes_mem_block_master.sv - self-checking bench with RAM, AES-core and memory-image model
module tb_aes_mem_block_master;

  logic         clk = 1'b0;
  logic         reset_n, start;
  logic [12:0]  src_addr, dst_addr;
  logic [11:0]  num_blocks;
  logic         busy, done, avm_chipselect, avm_write, avm_clken;
  logic [12:0]  avm_address;
  logic [3:0]   avm_byteenable;
  logic [31:0]  avm_writedata;
  logic [31:0]  avm_readdata = '0;
  logic         pt_valid, pt_ready, ct_valid, ct_ready;
  logic [127:0] pt_data, ct_data;

  always #5 clk = ~clk;

  aes_mem_block_master dut (
    .clk(clk), .reset_n(reset_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .num_blocks(num_blocks), .busy(busy), .done(done), .avm_address(avm_address),
    .avm_chipselect(avm_chipselect), .avm_write(avm_write), .avm_byteenable(avm_byteenable),
    .avm_writedata(avm_writedata), .avm_clken(avm_clken), .avm_readdata(avm_readdata),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0]  mem     [0:8191];
  logic [31:0]  ref_mem [0:8191];
  logic         mem_init = 1'b0;
  logic [44:0]  wr_log[$];
  logic [12:0]  rd_log[$];
  logic [127:0] pt_log[$];
  int           be_err = 0;

  int   cyc = 0, done_cnt = 0, cs_cnt = 0, busy_cnt = 0;
  int   start_cyc = 0, busy_rise = 0, done_cyc = 0;
  logic busy_prev = 1'b0;

  int ct_mode = 0, pt_stall = 0, ct_delay = 0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] xform(input logic [127:0] p, input int m);
    return (m == 0) ? ~p : (p ^ {4{32'hA5A5A5A5}});
  endfunction

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < 8192; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  // synchronous RAM: preload once, then 1-cycle read latency, logged accesses
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 8192; i++) mem[i] <= $urandom();
      mem_init <= 1'b1;
    end else if (avm_clken && avm_chipselect) begin
      if (avm_write) begin
        mem[avm_address] <= avm_writedata;
        wr_log.push_back({avm_address, avm_writedata});
        if (avm_byteenable != 4'hF) be_err <= be_err + 1;
      end else begin
        avm_readdata <= mem[avm_address];
        rd_log.push_back(avm_address);
      end
    end
  end

  // cycle monitor, sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    cyc++;
    if (start) start_cyc = cyc - 1;
    if (busy && !busy_prev) busy_rise = cyc;
    busy_prev = busy;
    if (busy) busy_cnt++;
    if (avm_chipselect) cs_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // AES core stand-in: optional plaintext stall, optional ciphertext delay
  initial begin
    logic [127:0] snap;
    int guard;
    pt_ready = 1'b0;
    ct_valid = 1'b0;
    ct_data  = '0;
    forever begin
      @(negedge clk);
      if (pt_valid === 1'b1) begin
        snap = pt_data;
        for (int i = 0; i < pt_stall; i++) begin
          @(negedge clk);
          check("pt_hold", {31'd0, pt_valid, pt_data}, {31'd0, 1'b1, snap});
        end
        pt_ready = 1'b1;
        pt_log.push_back(pt_data);
        @(negedge clk);
        pt_ready = 1'b0;
        for (int i = 0; i < ct_delay; i++) @(negedge clk);
        ct_data  = xform(snap, ct_mode);
        ct_valid = 1'b1;
        guard = 0;
        while (ct_ready !== 1'b1 && guard < 100) begin
          @(negedge clk);
          guard++;
        end
        @(negedge clk);
        ct_valid = 1'b0;
        ct_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
    end
  end

  int j_cs0, j_busy0;

  task automatic run_job(input logic [12:0] src, input logic [12:0] dst, input logic [11:0] n,
                         input int mode_i, input int stall_i, input int delay_i, input bit poke);
    logic [44:0]  exp_wr[$];
    logic [12:0]  exp_rd[$];
    logic [127:0] exp_pt[$];
    logic [31:0]  w[4];
    logic [12:0]  a;
    int wb, rb, pb, db, guard;
    ct_mode  = mode_i;
    pt_stall = stall_i;
    ct_delay = delay_i;
    // reference: blocks processed in order, each read fully before it is written
    for (int b = 0; b < int'(n); b++) begin
      for (int k = 0; k < 4; k++) begin
        a = 13'(int'(src) + 4 * b + k);
        w[k] = ref_mem[a];
        exp_rd.push_back(a);
      end
      exp_pt.push_back({w[0], w[1], w[2], w[3]});
      for (int k = 0; k < 4; k++) begin
        a = 13'(int'(dst) + 4 * b + k);
        ref_mem[a] = (mode_i == 0) ? ~w[k] : (w[k] ^ 32'hA5A5A5A5);
        exp_wr.push_back({a, ref_mem[a]});
      end
    end
    wb = wr_log.size(); rb = rd_log.size(); pb = pt_log.size(); db = done_cnt;
    j_cs0 = cs_cnt; j_busy0 = busy_cnt;
    @(negedge clk);
    start = 1'b1; src_addr = src; dst_addr = dst; num_blocks = n;
    @(negedge clk);
    start = 1'b0; src_addr = 13'($urandom()); dst_addr = 13'($urandom()); num_blocks = 12'($urandom());
    if (poke) begin
      repeat (3) @(negedge clk);
      start = 1'b1; src_addr = 13'h300; dst_addr = 13'h380; num_blocks = 12'd5;
      @(negedge clk);
      start = 1'b0;
    end
    guard = 0;
    while (done_cnt == db && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("done_timeout", (guard < 3000), 1);
    repeat (4) @(negedge clk);
    check("done_pulses", done_cnt - db, 1);
    check("wr_count", wr_log.size() - wb, exp_wr.size());
    for (int i = 0; i < exp_wr.size() && wb + i < wr_log.size(); i++)
      check("wr_entry", wr_log[wb + i], exp_wr[i]);
    check("rd_count", rd_log.size() - rb, exp_rd.size());
    for (int i = 0; i < exp_rd.size() && rb + i < rd_log.size(); i++)
      check("rd_addr", rd_log[rb + i], exp_rd[i]);
    check("pt_count", pt_log.size() - pb, exp_pt.size());
    for (int i = 0; i < exp_pt.size() && pb + i < pt_log.size(); i++)
      check("pt_block", pt_log[pb + i], exp_pt[i]);
    check("mem_image", mem_diffs(), 0);
    check("byteenable", be_err, 0);
  endtask

  initial begin
    int g, wb0;
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, wb0;
    reset_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; num_blocks = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {busy, done, avm_chipselect, avm_write, avm_address, avm_writedata, avm_byteenable,
           pt_valid, ct_ready, avm_clken},
          {1'b0, 1'b0, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1});
    for (int i = 0; i < 8192; i++) ref_mem[i] = mem[i];
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // single block, immediate handshakes, latency
    run_job(13'h000, 13'h100, 12'd1, 0, 0, 0, 1'b0);
    check("busy_rise", busy_rise - start_cyc, 1);
    check("blk_latency", done_cyc - busy_rise, 11);

    // stalled plaintext and delayed ciphertext
    run_job(13'h010, 13'h100, 12'd3, 0, 7, 20, 1'b0);

    // address wraparound
    run_job(13'h1FFE, 13'h1FFC, 12'd1, 0, 0, 0, 1'b0);

    // empty job
    run_job(13'h123, 13'h456, 12'd0, 0, 0, 0, 1'b0);
    check("empty_done_lat", done_cyc - start_cyc, 1);
    check("empty_no_cs", cs_cnt - j_cs0, 0);
    check("empty_no_busy", busy_cnt - j_busy0, 0);

    // start pulsed while busy is ignored
    run_job(13'h200, 13'h280, 12'd2, 1, 2, 3, 1'b1);

    // reset during the third write of the first block
    ct_mode = 0; pt_stall = 0; ct_delay = 0;
    wb0 = wr_log.size();
    @(negedge clk);
    start = 1'b1; src_addr = 13'h500; dst_addr = 13'h600; num_blocks = 12'd2;
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (!(avm_chipselect && avm_write && avm_address == 13'h602) && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("rst_reach_wr2", (g < 200), 1);
    reset_n = 1'b0;
    #1;
    check("rst_outputs",
          {busy, done, avm_chipselect, avm_write, avm_address, avm_writedata, avm_byteenable,
           pt_valid, ct_ready, avm_clken},
          {1'b0, 1'b0, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    ref_mem[13'h600] = ~ref_mem[13'h500];
    ref_mem[13'h601] = ~ref_mem[13'h501];
    check("rst_wr_count", wr_log.size() - wb0, 2);
    check("rst_mem_image", mem_diffs(), 0);
    check("rst_idle", {busy, avm_chipselect}, 2'b00);
    run_job(13'h700, 13'h780, 12'd2, 0, 1, 2, 1'b0);

    // in-place encryption
    run_job(13'h040, 13'h040, 12'd4, 1, 0, 0, 1'b0);

    // random jobs
    for (int j = 0; j < 3; j++)
      run_job(13'($urandom()), 13'($urandom()), 12'($urandom_range(1, 3)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
